// File: rtl/synchronous_fifo_ext.sv
// Single-clock FIFO with standard/FWFT read, programmable almost flags, fill level and
// registered overflow/underflow pulses. Define SYNCHRONOUS_FIFO_PARITY_EN for per-word parity.
module synchronous_fifo_ext #(
  parameter int G_WIDTH  = 8,
  parameter int G_DEPTH  = 4,
  parameter int G_AFULL  = 12,
  parameter int G_AEMPTY = 4,
  parameter int G_FWFT   = 0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_wr,
  input  logic [G_WIDTH-1:0] i_data,
  input  logic               i_rd,
  output logic [G_WIDTH-1:0] o_data,
  output logic               o_valid,
  output logic               o_full,
  output logic               o_empty,
  output logic               o_almost_full,
  output logic               o_almost_empty,
  output logic [G_DEPTH:0]   o_fill_level,
  output logic               o_overflow,
  output logic               o_underflow,
  output logic               o_parity_err
);

  localparam int LP_ENTRIES = 2 ** G_DEPTH;
`ifdef SYNCHRONOUS_FIFO_PARITY_EN
  localparam int LP_MW = G_WIDTH + 1;
`else
  localparam int LP_MW = G_WIDTH;
`endif

  if (G_AFULL < 1 || G_AFULL > LP_ENTRIES) begin : g_bad_afull
    $error("synchronous_fifo_ext: G_AFULL out of range 1..2**G_DEPTH");
  end
  if (G_AEMPTY < 0 || G_AEMPTY > LP_ENTRIES - 1) begin : g_bad_aempty
    $error("synchronous_fifo_ext: G_AEMPTY out of range 0..2**G_DEPTH-1");
  end

  logic [LP_MW-1:0] r_mem [LP_ENTRIES];
  logic [G_DEPTH:0] r_wr_ptr;
  logic [G_DEPTH:0] r_rd_ptr;
  logic             r_overflow;
  logic             r_underflow;
  logic [G_DEPTH:0] w_fill;
  logic             w_full;
  logic             w_empty;
  logic             w_wr_ok;
  logic             w_rd_ok;
  logic [LP_MW-1:0] w_wdata;
  logic [LP_MW-1:0] w_head;

  // Flags come only from registered pointers; the extra MSB separates full from empty.
  assign w_fill  = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_fill == (G_DEPTH+1)'(LP_ENTRIES));
  assign w_empty = (w_fill == '0);
  assign w_wr_ok = i_wr && !w_full;
  assign w_rd_ok = i_rd && !w_empty;
  assign w_head  = r_mem[r_rd_ptr[G_DEPTH-1:0]];

`ifdef SYNCHRONOUS_FIFO_PARITY_EN
  assign w_wdata = {^i_data, i_data};
`else
  assign w_wdata = i_data;
`endif

  assign o_full         = w_full;
  assign o_empty        = w_empty;
  assign o_almost_full  = (w_fill >= (G_DEPTH+1)'(G_AFULL));
  assign o_almost_empty = (w_fill <= (G_DEPTH+1)'(G_AEMPTY));
  assign o_fill_level   = w_fill;
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_overflow  <= i_wr && w_full;
      r_underflow <= i_rd && w_empty;
    end
  end

  // Storage is deliberately not reset; the pointers alone define valid contents.
  always_ff @(posedge i_clk) begin
    if (w_wr_ok) r_mem[r_wr_ptr[G_DEPTH-1:0]] <= w_wdata;
  end

  if (G_FWFT != 0) begin : g_fwft
    // Gate the head word while empty so stale memory never shows on o_data.
    assign o_data  = w_empty ? '0 : w_head[G_WIDTH-1:0];
    assign o_valid = !w_empty;
  end else begin : g_std
    logic [G_WIDTH-1:0] r_data;
    logic               r_valid;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_data  <= '0;
        r_valid <= 1'b0;
      end else begin
        r_valid <= w_rd_ok;
        if (w_rd_ok) r_data <= w_head[G_WIDTH-1:0];
      end
    end
    assign o_data  = r_data;
    assign o_valid = r_valid;
  end

`ifdef SYNCHRONOUS_FIFO_PARITY_EN
  logic r_parity_err;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                  r_parity_err <= 1'b0;
    else if (w_rd_ok && (^w_head)) r_parity_err <= 1'b1;
  end
  assign o_parity_err = r_parity_err;
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_synchronous_fifo_ext.sv
// Directed bench for synchronous_fifo_ext: a standard-mode instance plus an FWFT instance.
module tb_synchronous_fifo_ext;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr, rd;
  logic [7:0] din;
  logic [7:0] dout;
  logic       valid, full, empty, afull, aempty, ovf, unf, perr;
  logic [4:0] fill;

  logic       f_wr, f_rd;
  logic [7:0] f_din, f_dout;
  logic       f_valid, f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf, f_perr;
  logic [4:0] f_fill;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  synchronous_fifo_ext #(.G_WIDTH(8), .G_DEPTH(4), .G_AFULL(12), .G_AEMPTY(4), .G_FWFT(0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr(wr), .i_data(din), .i_rd(rd),
    .o_data(dout), .o_valid(valid), .o_full(full), .o_empty(empty),
    .o_almost_full(afull), .o_almost_empty(aempty), .o_fill_level(fill),
    .o_overflow(ovf), .o_underflow(unf), .o_parity_err(perr));

  synchronous_fifo_ext #(.G_WIDTH(8), .G_DEPTH(4), .G_AFULL(12), .G_AEMPTY(4), .G_FWFT(1)) dut_fwft (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr(f_wr), .i_data(f_din), .i_rd(f_rd),
    .o_data(f_dout), .o_valid(f_valid), .o_full(f_full), .o_empty(f_empty),
    .o_almost_full(f_afull), .o_almost_empty(f_aempty), .o_fill_level(f_fill),
    .o_overflow(f_ovf), .o_underflow(f_unf), .o_parity_err(f_perr));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr = 0; rd = 0; din = '0;
    f_wr = 0; f_rd = 0; f_din = '0;
    #12;
    n_cmp++; if (dout   !== 8'h00) begin n_err++; $display("FAIL reset_data got %h want 00", dout); end
    n_cmp++; if (valid  !== 1'b0)  begin n_err++; $display("FAIL reset_valid got %b want 0", valid); end
    n_cmp++; if (full   !== 1'b0)  begin n_err++; $display("FAIL reset_full got %b want 0", full); end
    n_cmp++; if (empty  !== 1'b1)  begin n_err++; $display("FAIL reset_empty got %b want 1", empty); end
    n_cmp++; if (afull  !== 1'b0)  begin n_err++; $display("FAIL reset_afull got %b want 0", afull); end
    n_cmp++; if (aempty !== 1'b1)  begin n_err++; $display("FAIL reset_aempty got %b want 1", aempty); end
    n_cmp++; if (fill   !== 5'd0)  begin n_err++; $display("FAIL reset_fill got %0d want 0", fill); end
    n_cmp++; if ({ovf, unf, perr} !== 3'b000) begin n_err++; $display("FAIL reset_pulses got %b want 000", {ovf, unf, perr}); end
    n_cmp++; if ({f_valid, f_dout} !== 9'h000) begin n_err++; $display("FAIL reset_fwft got %h want 000", {f_valid, f_dout}); end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    logic exp_af, exp_ae, exp_full;
    for (int i = 0; i < 16; i++) begin
      wr = 1; din = 8'(i);
      tick();
      exp_af   = (i + 1 >= 12);
      exp_ae   = (i + 1 <= 4);
      exp_full = (i == 15);
      n_cmp++; if (fill !== 5'(i + 1)) begin n_err++; $display("FAIL fill_level[%0d] got %0d want %0d", i, fill, i + 1); end
      n_cmp++; if ({full, afull, aempty} !== {exp_full, exp_af, exp_ae})
        begin n_err++; $display("FAIL fill_flags[%0d] got %b want %b", i, {full, afull, aempty}, {exp_full, exp_af, exp_ae}); end
    end
    wr = 0;
  endtask

  task automatic test_overflow();
    wr = 1; din = 8'hAA;
    tick();
    wr = 0;
    n_cmp++; if (ovf  !== 1'b1)  begin n_err++; $display("FAIL overflow_pulse got %b want 1", ovf); end
    n_cmp++; if (fill !== 5'd16) begin n_err++; $display("FAIL overflow_fill got %0d want 16", fill); end
    tick();
    n_cmp++; if (ovf  !== 1'b0)  begin n_err++; $display("FAIL overflow_clear got %b want 0", ovf); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      rd = 1;
      tick();
      n_cmp++; if ({valid, dout} !== {1'b1, 8'(i)})
        begin n_err++; $display("FAIL drain[%0d] got v=%b d=%h want v=1 d=%h", i, valid, dout, 8'(i)); end
    end
    rd = 0;
    tick();
    n_cmp++; if ({valid, empty, dout} !== {1'b0, 1'b1, 8'h0F})
      begin n_err++; $display("FAIL drain_end got v=%b e=%b d=%h want v=0 e=1 d=0f", valid, empty, dout); end
    n_cmp++; if (perr !== 1'b0) begin n_err++; $display("FAIL drain_parity got %b want 0", perr); end
  endtask

  task automatic test_underflow();
    rd = 1;
    tick();
    rd = 0;
    n_cmp++; if ({unf, valid} !== 2'b10) begin n_err++; $display("FAIL underflow_pulse got u=%b v=%b want u=1 v=0", unf, valid); end
    n_cmp++; if (fill !== 5'd0)         begin n_err++; $display("FAIL underflow_fill got %0d want 0", fill); end
    tick();
    n_cmp++; if ({unf, valid} !== 2'b00) begin n_err++; $display("FAIL underflow_clear got u=%b v=%b want 00", unf, valid); end
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 8; k++) begin
      wr = 1; din = 8'(8'h40 + k);
      tick();
    end
    for (int c = 0; c < 40; c++) begin
      wr = 1; rd = 1; din = 8'(8'h48 + c);
      tick();
      n_cmp++; if ({valid, dout} !== {1'b1, 8'(8'h40 + c)})
        begin n_err++; $display("FAIL wrap_data[%0d] got v=%b d=%h want v=1 d=%h", c, valid, dout, 8'(8'h40 + c)); end
      n_cmp++; if (fill !== 5'd8) begin n_err++; $display("FAIL wrap_fill[%0d] got %0d want 8", c, fill); end
    end
    wr = 0; rd = 0;
  endtask

  task automatic test_reset_mid_burst();
    wr = 1; din = 8'h70;
    tick();
    n_cmp++; if (fill !== 5'd9) begin n_err++; $display("FAIL midrst_prefill got %0d want 9", fill); end
    din = 8'h71;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({fill, empty, aempty, full, afull} !== {5'd0, 4'b1100})
      begin n_err++; $display("FAIL midrst_flags got f=%0d e=%b ae=%b fu=%b af=%b", fill, empty, aempty, full, afull); end
    n_cmp++; if ({valid, dout, ovf, unf} !== 11'h000)
      begin n_err++; $display("FAIL midrst_outputs got v=%b d=%h o=%b u=%b want all 0", valid, dout, ovf, unf); end
    rst_n = 1'b1; wr = 0;
    tick();
    n_cmp++; if (fill !== 5'd0) begin n_err++; $display("FAIL midrst_after got %0d want 0", fill); end
    wr = 1; din = 8'hC3;
    tick();
    wr = 0; rd = 1;
    n_cmp++; if (fill !== 5'd1) begin n_err++; $display("FAIL midrst_newfill got %0d want 1", fill); end
    tick();
    rd = 0;
    n_cmp++; if ({valid, dout} !== {1'b1, 8'hC3})
      begin n_err++; $display("FAIL midrst_newdata got v=%b d=%h want v=1 d=c3", valid, dout); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL midrst_empty got %b want 1", empty); end
  endtask

  task automatic test_fwft();
    f_wr = 1; f_din = 8'h5A;
    tick();
    f_wr = 0;
    n_cmp++; if ({f_valid, f_dout} !== {1'b1, 8'h5A})
      begin n_err++; $display("FAIL fwft_head got v=%b d=%h want v=1 d=5a", f_valid, f_dout); end
    tick();
    n_cmp++; if ({f_valid, f_dout, f_fill} !== {1'b1, 8'h5A, 5'd1})
      begin n_err++; $display("FAIL fwft_hold got v=%b d=%h f=%0d want 1 5a 1", f_valid, f_dout, f_fill); end
    f_rd = 1;
    tick();
    f_rd = 0;
    n_cmp++; if ({f_valid, f_empty} !== 2'b01)
      begin n_err++; $display("FAIL fwft_pop got v=%b e=%b want v=0 e=1", f_valid, f_empty); end
  endtask

`ifdef SYNCHRONOUS_FIFO_PARITY_EN
  task automatic test_parity();
    wr = 1; din = 8'h3C;
    tick();
    wr = 0;
    for (int k = 0; k < 16; k++) dut.r_mem[k][0] = ~dut.r_mem[k][0];
    rd = 1;
    n_cmp++; if (perr !== 1'b0) begin n_err++; $display("FAIL parity_pre got %b want 0", perr); end
    tick();
    rd = 0;
    n_cmp++; if ({perr, dout} !== {1'b1, 8'h3D})
      begin n_err++; $display("FAIL parity_set got p=%b d=%h want p=1 d=3d", perr, dout); end
    tick(); tick();
    n_cmp++; if (perr !== 1'b1) begin n_err++; $display("FAIL parity_sticky got %b want 1", perr); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (perr !== 1'b0) begin n_err++; $display("FAIL parity_reset got %b want 0", perr); end
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_underflow();
    test_wrap();
    test_reset_mid_burst();
    test_fwft();
`ifdef SYNCHRONOUS_FIFO_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
